fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the asynchronous FIFO, located in the write clock domain. It shares the single FIFO write port among NUM_REQ requesters. Each requester gets a burst of up to MAX_BURST words or one packet terminated by its last flag. FIFO full is honoured combinationally so that no write is ever issued into a full FIFO.

---
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants last up to MAX_BURST beats, one packet, or until STALL_MAX idle cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         wr_en_o,
    output logic [DATA_SIZE-1:0]         wr_data_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [BW-1:0]        beat_cnt_q;
    logic [SW-1:0]        stall_cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;

    logic [PW-1:0]        sel_d;
    logic                 sel_vld;
    logic [PW:0]          scan_sum;
    logic [PW-1:0]        scan_idx;
    logic                 vld_g;
    logic                 last_g;
    logic [DATA_SIZE-1:0] data_g;
    logic                 xfer;
    logic                 done;
    logic [PW-1:0]        ptr_d;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        sel_d    = '0;
        sel_vld  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (PW + 1)'(k);
            if (scan_sum >= (PW + 1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PW + 1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (req_valid_i[scan_idx]) begin
                sel_d   = scan_idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                data_g = req_data_i[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign vld_g  = req_valid_i[gidx_q];
    assign last_g = req_last_i[gidx_q];
    assign xfer   = busy_q & vld_g & ~fifo_full_i;

    assign done = (xfer & (last_g | (beat_cnt_q == BW'(MAX_BURST - 1))))
                | (busy_q & ~vld_g & (stall_cnt_q == SW'(STALL_MAX - 1)));

    assign ptr_d = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

    assign wr_en_o     = xfer & ~rst_i;
    assign req_ready_o = wr_en_o ? grant_q : '0;
    assign wr_data_o   = data_g;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        state_q     <= BURST;
                        gidx_q      <= sel_d;
                        grant_q     <= NUM_REQ'(1) << sel_d;
                        busy_q      <= 1'b1;
                        beat_cnt_q  <= '0;
                        stall_cnt_q <= '0;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt_q  <= beat_cnt_q + BW'(1);
                        stall_cnt_q <= '0;
                    end else if (!vld_g) begin
                        stall_cnt_q <= stall_cnt_q + SW'(1);
                    end
                    if (done) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner cases and
// randomized traffic into a modelled FIFO with a slow reader.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SM = 8;
    localparam int FIFO_DEPTH = 8;

    localparam logic [31:0] BASE = 32'h3320_1100;
    localparam logic [31:0] A1   = 32'h33A1_1100;
    localparam logic [31:0] A2   = 32'h33A2_1100;
    localparam logic [31:0] A3   = 32'h33A3_1100;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [N*DW-1:0] d;
    logic          full;
    logic [N-1:0]  rdy;
    logic          wr_en;
    logic [DW-1:0] wd;
    logic [N-1:0]  gnt;
    logic          busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (N),
        .DATA_SIZE(DW),
        .MAX_BURST(MB),
        .STALL_MAX(SM)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(v),
        .req_last_i (l),
        .req_data_i (d),
        .req_ready_o(rdy),
        .fifo_full_i(full),
        .wr_en_o    (wr_en),
        .wr_data_o  (wd),
        .grant_o    (gnt),
        .busy_o     (busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  eg;
        logic        eb;
        logic        ew;
        logic [3:0]  er;
        logic        cw;
        logic [7:0]  ewd;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        v    = '0;
        l    = '0;
        full = 1'b0;
        d    = BASE;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    // Random-phase state
    bit        pend[N];
    bit        plast[N];
    logic [7:0] pdat[N];
    int        seqn[N];
    int        rate[N];
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int        owner, beats, idles, ptr;
    bit        exp_wr, endb;
    logic [7:0] f_word, e_word;

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, BASE, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'h4, 4'h0, 1'b0, A1,   4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h4, 4'h0, 1'b0, A1,   4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 8'hA1};
        tbl[3]  = '{1'b0, 4'h4, 4'h4, 1'b0, A2,   4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 8'hA2};
        tbl[4]  = '{1'b0, 4'hC, 4'h0, 1'b0, A3,   4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 4'hC, 4'h0, 1'b0, A3,   4'h8, 1'b1, 1'b1, 4'h8, 1'b1, 8'h33};
        tbl[6]  = '{1'b0, 4'hC, 4'h0, 1'b1, A3,   4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 8'h33};
        tbl[7]  = '{1'b1, 4'hC, 4'h0, 1'b0, A3,   4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 8'h33};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 1'b0, BASE, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 1'b0, BASE, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h00};
        tbl[10] = '{1'b0, 4'hF, 4'h1, 1'b0, BASE, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 4'hF, 4'h0, 1'b0, BASE, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 4'hF, 4'h0, 1'b0, BASE, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 8'h11};

        // Vector table: packet end, rr_ptr advance, full, reset mid-burst
        do_reset();
        for (int i = 0; i < 13; i++) begin
            rst  = tbl[i].rst;
            v    = tbl[i].v;
            l    = tbl[i].l;
            full = tbl[i].f;
            d    = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d grant", i), 32'(gnt), 32'(tbl[i].eg));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].ew));
            chk($sformatf("vec%0d ready", i), 32'(rdy), 32'(tbl[i].er));
            if (tbl[i].cw) begin
                chk($sformatf("vec%0d wr_data", i), 32'(wd), 32'(tbl[i].ewd));
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // Round-robin: all valid, no last
        begin
            int writes;
            logic [3:0] prevg;
            logic [3:0] gseq[$];
            do_reset();
            v = 4'hF;
            writes = 0;
            prevg = '0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (wr_en) writes++;
                if (gnt != 4'h0 && prevg == 4'h0) gseq.push_back(gnt);
                prevg = gnt;
                @(posedge clk);
                #1;
            end
            chk("rr writes", 32'(writes), 32'd20);
            chk("rr bursts", 32'(gseq.size()), 32'd5);
            for (int k = 0; k < 5 && k < gseq.size(); k++) begin
                chk($sformatf("rr grant%0d", k), 32'(gseq[k]), 32'(1 << (k % 4)));
            end
        end

        // Full back-pressure mid-burst on requester 1
        begin
            logic [7:0] got[$];
            logic [7:0] word;
            do_reset();
            word = 8'h50;
            v = 4'b0010;
            for (int c = 0; c < 9; c++) begin
                full = (c >= 3 && c <= 5);
                d = BASE;
                d[DW +: DW] = word;
                @(negedge clk);
                if (full) begin
                    chk($sformatf("bp wr_en c%0d", c), 32'(wr_en), 32'd0);
                    chk($sformatf("bp ready c%0d", c), 32'(rdy), 32'd0);
                    chk($sformatf("bp grant c%0d", c), 32'(gnt), 32'h2);
                end
                if (wr_en) got.push_back(wd);
                if (rdy[1]) word = word + 8'd1;
                @(posedge clk);
                #1;
            end
            full = 1'b0;
            chk("bp count", 32'(got.size()), 32'd4);
            for (int k = 0; k < 4 && k < got.size(); k++) begin
                chk($sformatf("bp word%0d", k), 32'(got[k]), 32'(8'h50 + k));
            end
        end

        // Stall revoke: requester 1 granted then silent, requester 2 waits
        begin
            int held;
            do_reset();
            v = 4'b0010;
            @(posedge clk);
            #1;
            v = 4'b0100;
            held = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (gnt !== 4'b0010) break;
                held++;
                @(posedge clk);
                #1;
            end
            chk("stall held", 32'(held), 32'd8);
            chk("stall idle grant", 32'(gnt), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("stall next grant", 32'(gnt), 32'h4);
            @(posedge clk);
            #1;
        end

        // Random traffic into a shallow FIFO drained every third cycle
        do_reset();
        rate[0] = 60;
        rate[1] = 30;
        rate[2] = 80;
        rate[3] = 10;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            plast[i] = 1'b0;
            pdat[i]  = '0;
            seqn[i]  = 0;
        end
        owner = -1;
        beats = 0;
        idles = 0;
        ptr   = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < rate[i]) begin
                    pend[i]  = 1'b1;
                    pdat[i]  = {2'(i), 6'(seqn[i])};
                    plast[i] = ($urandom_range(0, 3) == 0);
                    seqn[i]++;
                end
                v[i] = pend[i];
                l[i] = plast[i];
                d[i*DW +: DW] = pdat[i];
            end
            full = (fq.size() >= FIFO_DEPTH);
            @(negedge clk);
            exp_wr = (owner >= 0) && pend[owner] && !full;
            chk("rnd grant", 32'(gnt), (owner < 0) ? 32'd0 : 32'(1 << owner));
            chk("rnd busy", 32'(busy), 32'(owner >= 0));
            chk("rnd wr_en", 32'(wr_en), 32'(exp_wr));
            chk("rnd ready", 32'(rdy), exp_wr ? 32'(1 << owner) : 32'd0);
            chk("rnd overflow", 32'(wr_en & full), 32'd0);
            if (owner >= 0) chk("rnd wr_data", 32'(wd), 32'(pdat[owner]));
            if (wr_en) fq.push_back(wd);
            if (exp_wr) exp_q.push_back(pdat[owner]);
            @(posedge clk);
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (pend[(ptr + k) % N]) begin
                        owner = (ptr + k) % N;
                        beats = 0;
                        idles = 0;
                        break;
                    end
                end
            end else if (exp_wr) begin
                beats++;
                idles = 0;
                endb = plast[owner] || (beats == MB);
                pend[owner] = 1'b0;
                if (endb) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                end
            end else if (!pend[owner]) begin
                idles++;
                if (idles == SM) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                end
            end
            if (cyc % 3 == 0 && fq.size() > 0) begin
                f_word = fq.pop_front();
                if (exp_q.size() == 0) begin
                    chk("rnd read unexpected", 32'(f_word), 32'hFFFF_FFFF);
                end else begin
                    e_word = exp_q.pop_front();
                    chk("rnd read order", 32'(f_word), 32'(e_word));
                end
            end
            #1;
        end
        v = '0;
        chk("rnd drain size", 32'(fq.size()), 32'(exp_q.size()));
        while (fq.size() > 0 && exp_q.size() > 0) begin
            f_word = fq.pop_front();
            e_word = exp_q.pop_front();
            chk("rnd drain order", 32'(f_word), 32'(e_word));
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
